// File: rtl/trace_store_if.sv
// Host readout and trace-RAM port bundle for trace_store_ctrl.
// The controller takes the master side; the RAM and host take the slave side.
interface trace_store_if #(
  parameter int TRACE_WIDTH = 128,
  parameter int ADDR_W      = 8
);
  logic                   host_rd_req_i;
  logic [ADDR_W-1:0]      host_rd_addr_i;
  logic                   host_rd_valid_o;
  logic [TRACE_WIDTH-1:0] host_rd_data_o;
  logic                   mem_en_o;
  logic                   mem_we_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [TRACE_WIDTH-1:0] mem_wdata_o;
  logic [TRACE_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  host_rd_req_i, host_rd_addr_i, mem_rdata_i,
    output host_rd_valid_o, host_rd_data_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output host_rd_req_i, host_rd_addr_i, mem_rdata_i,
    input  host_rd_valid_o, host_rd_data_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/trace_store_ctrl.sv
// Circular trace-RAM sequencer sharing one RAM port between capture and host readout.
// Define TRACE_STOP_ON_FULL_EN to freeze capture when the RAM fills instead of overwriting.
module trace_store_ctrl #(
  parameter int TRACE_WIDTH = 128,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trace_valid_i,
  input  logic [TRACE_WIDTH-1:0] trace_data_i,
  input  logic                   trace_cap_en_i,
  input  logic                   lock_i,
  trace_store_if.master          bus,
  output logic [ADDR_W-1:0]      wr_ptr_o,
  output logic [ADDR_W:0]        count_o,
  output logic                   wrapped_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t                 state_q, state_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [TRACE_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
  logic                   rd_inflight_q;
  logic [ADDR_W-1:0]      wr_ptr_q;
  logic [ADDR_W:0]        count_q;
  logic                   wrapped_q;

  logic                   accept;
  logic                   wr_fire;
  logic                   rd_grant;
  logic                   fill_now;
  logic [TRACE_WIDTH-1:0] wr_data;

  // Port arbitration: a parked skid record drains first, then a pending read,
  // then the incoming record. A read is only granted with the skid empty, so a
  // record arriving alongside the read always has somewhere to go.
  always_comb begin
    accept       = (state_q == S_CAPTURE) && trace_valid_i && trace_cap_en_i;
`ifdef TRACE_STOP_ON_FULL_EN
    accept       = accept && (count_q != FULL_CNT);
`endif
    wr_fire      = 1'b0;
    rd_grant     = 1'b0;
    wr_data      = trace_data_i;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q) begin
      wr_fire      = 1'b1;
      wr_data      = skid_data_q;
      skid_valid_d = accept;
      if (accept) skid_data_d = trace_data_i;
    end else if (pend_valid_q) begin
      rd_grant = 1'b1;
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = trace_data_i;
      end
    end else if (accept) begin
      wr_fire = 1'b1;
    end

    fill_now = wr_fire && (count_q == FULL_CNT - 1'b1);
`ifdef TRACE_STOP_ON_FULL_EN
    if (fill_now) skid_valid_d = 1'b0;
`endif

    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (bus.host_rd_req_i) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = bus.host_rd_addr_i;
    end else if (rd_grant) begin
      pend_valid_d = 1'b0;
    end
  end

  // Next-state logic; FROZEN only leaves through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (trace_cap_en_i && !lock_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (lock_i) state_d = S_DRAIN;
`ifdef TRACE_STOP_ON_FULL_EN
        if (fill_now) state_d = S_FROZEN;
`endif
      end
      S_DRAIN:   state_d = skid_valid_q ? S_DRAIN : S_FROZEN;
      S_FROZEN:  state_d = S_FROZEN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      rd_inflight_q <= 1'b0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      wrapped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      rd_inflight_q <= rd_grant;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q != FULL_CNT) count_q <= count_q + 1'b1;
`ifndef TRACE_STOP_ON_FULL_EN
        if (&wr_ptr_q) wrapped_q <= 1'b1;
`endif
      end
    end
  end

  // Outputs are masked while rst_n is low so a read already in flight never
  // surfaces during the reset cycle.
  always_comb begin
    bus.mem_en_o        = rst_n && (wr_fire || rd_grant);
    bus.mem_we_o        = rst_n && wr_fire;
    bus.mem_addr_o      = rd_grant ? pend_addr_q : wr_ptr_q;
    bus.mem_wdata_o     = wr_data;
    bus.host_rd_valid_o = rst_n && rd_inflight_q;
    bus.host_rd_data_o  = (rst_n && rd_inflight_q) ? bus.mem_rdata_i : '0;
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_trace_store_ctrl.sv
// Directed bench for trace_store_ctrl with a behavioural single-port RAM model.
// Cycle vectors cover capture, arbitration, lock/drain and reset; wrap/full is hand-sequenced.
module tb_trace_store_ctrl;
  localparam int TW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic          rst_n, cap_en, valid, lock, req;
    logic [TW-1:0] data;
    logic [AW-1:0] raddr;
    logic          en, we;
    logic [AW-1:0] addr, wr;
    logic [AW:0]   cnt;
    logic [1:0]    st;
    logic          rv;
    logic [TW-1:0] rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, trace_valid, trace_cap_en, lock;
  logic [TW-1:0] trace_data;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          wrapped;
  logic [1:0]    state;

  int   errors = 0;
  int   checks = 0;
  int   cur_row = 0;
  vec_t vecs[$];

  trace_store_if #(.TRACE_WIDTH(TW), .ADDR_W(AW)) bus ();

  trace_store_ctrl #(.TRACE_WIDTH(TW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_valid_i  (trace_valid),
    .trace_data_i   (trace_data),
    .trace_cap_en_i (trace_cap_en),
    .lock_i         (lock),
    .bus            (bus),
    .wr_ptr_o       (wr_ptr),
    .count_o        (count),
    .wrapped_o      (wrapped),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency
  logic [TW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i     <= ram[bus.mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (row %0d): got %0h, expected %0h", name, cur_row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, c, v, input logic [TW-1:0] d, input logic l, q,
                              input logic [AW-1:0] ra, input logic en, we,
                              input logic [AW-1:0] ad, wr, input logic [AW:0] cn,
                              input logic [1:0] st, input logic rv, input logic [TW-1:0] rd);
    vec_t x;
    x.rst_n = r; x.cap_en = c; x.valid = v; x.data = d; x.lock = l; x.req = q; x.raddr = ra;
    x.en = en; x.we = we; x.addr = ad; x.wr = wr; x.cnt = cn; x.st = st; x.rv = rv; x.rdata = rd;
    return x;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n              = v.rst_n;
    trace_cap_en       = v.cap_en;
    trace_valid        = v.valid;
    trace_data         = v.data;
    lock               = v.lock;
    bus.host_rd_req_i  = v.req;
    bus.host_rd_addr_i = v.raddr;
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    chk("mem_en", bus.mem_en_o, v.en);
    if (v.en) begin
      chk("mem_we", bus.mem_we_o, v.we);
      chk("mem_addr", bus.mem_addr_o, v.addr);
    end
    chk("wr_ptr", wr_ptr, v.wr);
    chk("count", count, v.cnt);
    chk("state", state, v.st);
    chk("wrapped", wrapped, 1'b0);
    chk("rd_valid", bus.host_rd_valid_o, v.rv);
    if (v.rv) chk("rd_data", bus.host_rd_data_o, v.rdata);
  endtask

  task automatic doReset();
    applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
  endtask

  initial begin
    logic [AW-1:0] exp_wr;
    logic          exp_wrapped;
    logic [1:0]    exp_st;
    logic [TW-1:0] exp_addr0;
    logic          got;

    //          rst cap val data    lk req ra   en we ad  wr  cnt st rv rdata
    vecs.push_back(mk(1,1,1,'h055,0,0,0,  0,0,0,  0, 0, 0,0,0));
    vecs.push_back(mk(1,1,1,'h100,0,0,0,  1,1,0,  0, 0, 1,0,0));
    vecs.push_back(mk(1,1,1,'h101,0,0,0,  1,1,1,  1, 1, 1,0,0));
    vecs.push_back(mk(1,1,1,'h102,0,0,0,  1,1,2,  2, 2, 1,0,0));
    vecs.push_back(mk(1,1,1,'h103,0,1,1,  1,1,3,  3, 3, 1,0,0));
    vecs.push_back(mk(1,1,1,'h104,0,0,0,  1,0,1,  4, 4, 1,0,0));
    vecs.push_back(mk(1,1,1,'h105,0,0,0,  1,1,4,  4, 4, 1,1,'h101));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  1,1,5,  5, 5, 1,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  0,0,0,  6, 6, 1,0,0));
    vecs.push_back(mk(1,1,1,'h106,0,1,4,  1,1,6,  6, 6, 1,0,0));
    vecs.push_back(mk(1,1,1,'h107,0,0,0,  1,0,4,  7, 7, 1,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,1,0,  1,1,7,  7, 7, 1,1,'h104));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  1,0,0,  8, 8, 1,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  0,0,0,  8, 8, 1,1,'h100));
    vecs.push_back(mk(1,1,1,'h108,0,1,2,  1,1,8,  8, 8, 1,0,0));
    vecs.push_back(mk(1,1,1,'h109,0,1,5,  1,0,2,  9, 9, 1,0,0));
    vecs.push_back(mk(1,1,1,'h10A,0,1,6,  1,1,9,  9, 9, 1,1,'h102));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  1,1,10, 10,10,1,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  1,0,6,  11,11,1,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  0,0,0,  11,11,1,1,'h106));
    vecs.push_back(mk(1,1,1,'h10B,0,1,7,  1,1,11, 11,11,1,0,0));
    vecs.push_back(mk(1,1,1,'h10C,0,0,0,  1,0,7,  12,12,1,0,0));
    vecs.push_back(mk(1,1,1,'h10D,1,0,0,  1,1,12, 12,12,1,1,'h107));
    vecs.push_back(mk(1,1,1,'h10E,1,0,0,  1,1,13, 13,13,2,0,0));
    vecs.push_back(mk(1,1,1,'h10F,1,1,12, 0,0,0,  14,14,2,0,0));
    vecs.push_back(mk(1,1,1,'h110,1,0,0,  1,0,12, 14,14,3,0,0));
    vecs.push_back(mk(1,1,0,'h000,1,0,0,  0,0,0,  14,14,3,1,'h10C));
    vecs.push_back(mk(1,1,0,'h000,0,1,1,  0,0,0,  14,14,3,0,0));
    vecs.push_back(mk(1,1,0,'h000,0,0,0,  1,0,1,  14,14,3,0,0));
    vecs.push_back(mk(0,0,0,'h000,0,0,0,  0,0,0,  14,14,3,0,0));
    vecs.push_back(mk(1,0,0,'h000,0,0,0,  0,0,0,  0, 0, 0,0,0));
    vecs.push_back(mk(1,0,0,'h000,0,0,0,  0,0,0,  0, 0, 0,0,0));

    doReset();
    chk("reset_state", state, 2'd0);
    chk("reset_count", count, 0);
    chk("reset_wr_ptr", wr_ptr, 0);
    chk("reset_rd_valid", bus.host_rd_valid_o, 1'b0);
    chk("reset_mem_en", bus.mem_en_o, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row = i + 1;
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // DEPTH+2 back-to-back records: wrap vs. stop-on-full
    cur_row = 100;
    doReset();
    applyStimulus(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(mk(1,1,1,TW'('h200 + i),0,0,0, 0,0,0,0,0,0,0,0));
    applyStimulus(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
`ifdef TRACE_STOP_ON_FULL_EN
    exp_wr = 0; exp_wrapped = 1'b0; exp_st = 2'd3; exp_addr0 = 'h200;
`else
    exp_wr = 2; exp_wrapped = 1'b1; exp_st = 2'd1; exp_addr0 = TW'('h200 + DEPTH);
`endif
    chk("full_wr_ptr", wr_ptr, exp_wr);
    chk("full_count", count, DEPTH);
    chk("full_wrapped", wrapped, exp_wrapped);
    chk("full_state", state, exp_st);

    applyStimulus(mk(1,1,0,0,0,1,0, 0,0,0,0,0,0,0,0));
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      applyStimulus(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      if (bus.host_rd_valid_o) begin
        got = 1'b1;
        chk("full_addr0_data", bus.host_rd_data_o, exp_addr0);
      end
    end
    chk("full_rd_timeout", got, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
